bcd_game_timer: RTL and testbench

Parametrised multi-digit BCD countdown timer for the game-time display. It generalises the fixed 2-digit, 25-second countdown:
- N-digit width and configurable start value.
- Internal tick prescaler, so no external divided clock is needed.
- Pause, bonus-time add with BCD carry and saturation, low-time warning, expiry flags.

It sits between the game FSM, which drives game_state, and the seven-segment interface, which consumes digits_bcd.

---
 rtl/bcd_game_timer.sv | 147 ++++++++++++++
 tb/tb_bcd_game_timer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_game_timer.sv
// Parametrised N-digit BCD countdown timer for the game-time display.
// Internal tick prescaler, pause, saturating bonus add, warning and expiry flags.
module bcd_game_timer #(
    parameter int                        NUM_DIGITS = 4,
    parameter logic [4*NUM_DIGITS-1:0]   START_BCD  = 16'h0025,
    parameter logic [4*NUM_DIGITS-1:0]   WARN_BCD   = 16'h0005,
    parameter int                        TICK_DIV   = 100_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              game_state,
    input  logic                    pause,
    input  logic                    add_valid,
    input  logic [4*NUM_DIGITS-1:0] add_bcd,
    output logic [4*NUM_DIGITS-1:0] digits_bcd,
    output logic                    tick,
    output logic                    expired,
    output logic                    expired_pulse,
    output logic                    warn,
    output logic                    add_err
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE           = 2'b00,
        OPENING_SCREEN = 2'b01,
        GAME_RUNNING   = 2'b10,
        GAME_OVER      = 2'b11
    } game_state_e;

    // Subtract one with borrow rippling across digits; only called on a nonzero count.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        logic [3:0]   d;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = v[4*i +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    d = 4'd9;
                end else begin
                    d      = d - 4'd1;
                    borrow = 1'b0;
                end
            end
            r[4*i +: 4] = d;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_add_sat(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [W-1:0] all_nines;
        logic         carry;
        logic [4:0]   s;
        carry = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, carry};
            if (s > 5'd9) begin
                s     = s - 5'd10;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            r[4*i +: 4]         = s[3:0];
            all_nines[4*i +: 4] = 4'd9;
        end
        return carry ? all_nines : r;
    endfunction

    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    game_state_e   state;
    logic [W-1:0]  count;
    logic [PW-1:0] presc;
    logic          running;
    logic          count_zero;
    logic          presc_en;
    logic          tick_en;
    logic          add_try;
    logic          add_ok;
    logic          add_bad;
    logic [W-1:0]  dec_val;
    logic [W-1:0]  count_next;

    assign state = game_state_e'(game_state);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        running    = (state == GAME_RUNNING);
        count_zero = (count == '0);
        presc_en   = running && !pause && !count_zero;
        tick_en    = presc_en && (presc == PRESC_MAX);
        add_try    = running && !count_zero && !pause && add_valid;
        add_ok     = add_try && bcd_valid(add_bcd);
        add_bad    = add_try && !bcd_valid(add_bcd);
        dec_val    = tick_en ? bcd_dec(count) : count;
        count_next = add_ok ? bcd_add_sat(dec_val, add_bcd) : dec_val;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count         <= START_BCD;
            presc         <= '0;
            tick          <= 1'b0;
            expired_pulse <= 1'b0;
            add_err       <= 1'b0;
        end else begin
            tick          <= 1'b0;
            expired_pulse <= 1'b0;
            add_err       <= 1'b0;
            case (state)
                IDLE, OPENING_SCREEN: begin
                    count <= START_BCD;
                    presc <= '0;
                end
                GAME_RUNNING: begin
                    count <= count_next;
                    if (presc_en) presc <= tick_en ? '0 : presc + 1'b1;
                    tick          <= tick_en;
                    expired_pulse <= !count_zero && (count_next == '0);
                    add_err       <= add_bad;
                end
                default: ; // GAME_OVER freezes count and prescaler
            endcase
        end
    end

    assign digits_bcd = count;
    assign expired    = count_zero && (state == GAME_RUNNING || state == GAME_OVER);
    // Valid BCD orders the same as binary, so a plain compare works.
    assign warn       = !count_zero && (count <= WARN_BCD);

endmodule

// File: tb/tb_bcd_game_timer.sv
// Directed bench for bcd_game_timer: three instances share stimulus and differ only in start value.
module tb_bcd_game_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  game_state = 2'b00;
    logic        pause = 1'b0;
    logic        add_valid = 1'b0;
    logic [15:0] add_bcd = 16'h0000;

    logic [15:0] digits_a, digits_b, digits_c;
    logic        tick_a, tick_b, tick_c;
    logic        expired_a, expired_b, expired_c;
    logic        epulse_a, epulse_b, epulse_c;
    logic        warn_a, warn_b, warn_c;
    logic        err_a, err_b, err_c;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b10, S_OVER = 2'b11;

    always #5 clk = ~clk;

    bcd_game_timer #(.NUM_DIGITS(4), .START_BCD(16'h0025), .WARN_BCD(16'h0005), .TICK_DIV(4)) dut_a (
        .clk(clk), .rst(rst), .game_state(game_state), .pause(pause), .add_valid(add_valid),
        .add_bcd(add_bcd), .digits_bcd(digits_a), .tick(tick_a), .expired(expired_a),
        .expired_pulse(epulse_a), .warn(warn_a), .add_err(err_a));

    bcd_game_timer #(.NUM_DIGITS(4), .START_BCD(16'h1000), .WARN_BCD(16'h0005), .TICK_DIV(4)) dut_b (
        .clk(clk), .rst(rst), .game_state(game_state), .pause(pause), .add_valid(add_valid),
        .add_bcd(add_bcd), .digits_bcd(digits_b), .tick(tick_b), .expired(expired_b),
        .expired_pulse(epulse_b), .warn(warn_b), .add_err(err_b));

    bcd_game_timer #(.NUM_DIGITS(4), .START_BCD(16'h0002), .WARN_BCD(16'h0005), .TICK_DIV(4)) dut_c (
        .clk(clk), .rst(rst), .game_state(game_state), .pause(pause), .add_valid(add_valid),
        .add_bcd(add_bcd), .digits_bcd(digits_c), .tick(tick_c), .expired(expired_c),
        .expired_pulse(epulse_c), .warn(warn_c), .add_err(err_c));

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; game_state = S_IDLE; pause = 1'b0; add_valid = 1'b0; add_bcd = 16'h0000;
        step(1);
        total++; if (digits_a !== 16'h0025) begin bad++; $display("FAIL reset_digits: got %h want 0025", digits_a); end
        total++; if ({tick_a, epulse_a, err_a, expired_a, warn_a} !== 5'b00000) begin bad++; $display("FAIL reset_flags: got %b want 00000", {tick_a, epulse_a, err_a, expired_a, warn_a}); end
        total++; if (warn_c !== 1'b1) begin bad++; $display("FAIL reset_warn_start: got %b want 1", warn_c); end
        rst = 1'b0;
        step(3);
        total++; if (digits_a !== 16'h0025 || tick_a !== 1'b0) begin bad++; $display("FAIL idle_hold: got %h/%b want 0025/0", digits_a, tick_a); end
    endtask

    task automatic test_decrement;
        test_reset();
        game_state = S_RUN;
        step(3);
        total++; if (digits_a !== 16'h0025 || tick_a !== 1'b0) begin bad++; $display("FAIL dec_early: got %h/%b want 0025/0", digits_a, tick_a); end
        step(1);
        total++; if (digits_a !== 16'h0024 || tick_a !== 1'b1) begin bad++; $display("FAIL dec_first: got %h/%b want 0024/1", digits_a, tick_a); end
        total++; if (digits_b !== 16'h0999) begin bad++; $display("FAIL dec_1000: got %h want 0999", digits_b); end
        step(1);
        total++; if (tick_a !== 1'b0) begin bad++; $display("FAIL tick_one_cycle: got %b want 0", tick_a); end
        step(15);
        total++; if (digits_a !== 16'h0020) begin bad++; $display("FAIL dec_to_20: got %h want 0020", digits_a); end
        step(4);
        total++; if (digits_a !== 16'h0019) begin bad++; $display("FAIL dec_20_19: got %h want 0019", digits_a); end
    endtask

    task automatic test_expire;
        test_reset();
        game_state = S_RUN;
        step(4);
        total++; if (digits_c !== 16'h0001 || warn_c !== 1'b1 || expired_c !== 1'b0) begin bad++; $display("FAIL exp_one: got %h w%b e%b want 0001 w1 e0", digits_c, warn_c, expired_c); end
        step(4);
        total++; if (digits_c !== 16'h0000 || epulse_c !== 1'b1 || expired_c !== 1'b1) begin bad++; $display("FAIL exp_zero: got %h p%b e%b want 0000 p1 e1", digits_c, epulse_c, expired_c); end
        total++; if (warn_c !== 1'b0) begin bad++; $display("FAIL exp_warn_drop: got %b want 0", warn_c); end
        step(1);
        total++; if (epulse_c !== 1'b0 || expired_c !== 1'b1) begin bad++; $display("FAIL exp_pulse_once: got p%b e%b want p0 e1", epulse_c, expired_c); end
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (tick_c !== 1'b0 || epulse_c !== 1'b0) begin
                total++; bad++; $display("FAIL exp_quiet: cycle %0d tick %b pulse %b want 0/0", i, tick_c, epulse_c);
            end
        end
        total++; if (digits_c !== 16'h0000 || expired_c !== 1'b1) begin bad++; $display("FAIL exp_hold: got %h e%b want 0000 e1", digits_c, expired_c); end
        game_state = S_IDLE;
        #1;
        total++; if (expired_c !== 1'b0) begin bad++; $display("FAIL exp_idle_clear: got %b want 0", expired_c); end
        step(1);
        total++; if (digits_c !== 16'h0002) begin bad++; $display("FAIL exp_reload: got %h want 0002", digits_c); end
    endtask

    task automatic test_pause;
        test_reset();
        game_state = S_RUN;
        step(6);
        pause = 1'b1;
        step(10);
        total++; if (digits_a !== 16'h0024 || tick_a !== 1'b0) begin bad++; $display("FAIL pause_freeze: got %h/%b want 0024/0", digits_a, tick_a); end
        pause = 1'b0;
        step(1);
        total++; if (digits_a !== 16'h0024) begin bad++; $display("FAIL pause_resume_wait: got %h want 0024", digits_a); end
        step(1);
        total++; if (digits_a !== 16'h0023 || tick_a !== 1'b1) begin bad++; $display("FAIL pause_resume_phase: got %h/%b want 0023/1", digits_a, tick_a); end
    endtask

    task automatic test_add;
        test_reset();
        game_state = S_RUN;
        step(4);
        add_valid = 1'b1; add_bcd = 16'h0030;
        step(1);
        total++; if (digits_a !== 16'h0054 || err_a !== 1'b0) begin bad++; $display("FAIL add_basic: got %h e%b want 0054 e0", digits_a, err_a); end
        add_bcd = 16'h9936;
        step(1);
        total++; if (digits_a !== 16'h9990) begin bad++; $display("FAIL add_carry: got %h want 9990", digits_a); end
        add_bcd = 16'h0030;
        step(1);
        total++; if (digits_a !== 16'h9999) begin bad++; $display("FAIL add_saturate: got %h want 9999", digits_a); end
        add_valid = 1'b0;
        step(1);
        total++; if (digits_a !== 16'h9998) begin bad++; $display("FAIL add_then_tick: got %h want 9998", digits_a); end
        add_valid = 1'b1; add_bcd = 16'h00A1;
        step(1);
        add_valid = 1'b0;
        total++; if (digits_a !== 16'h9998 || err_a !== 1'b1) begin bad++; $display("FAIL add_bad_nibble: got %h e%b want 9998 e1", digits_a, err_a); end
        step(1);
        total++; if (err_a !== 1'b0) begin bad++; $display("FAIL add_err_once: got %b want 0", err_a); end
    endtask

    task automatic test_back_to_back;
        test_reset();
        game_state = S_RUN;
        step(7);
        add_valid = 1'b1; add_bcd = 16'h0010;
        step(1);
        add_valid = 1'b0;
        total++; if (digits_a !== 16'h0033 || tick_a !== 1'b1) begin bad++; $display("FAIL sim_tick_add: got %h/%b want 0033/1", digits_a, tick_a); end
        test_reset();
        game_state = S_RUN;
        step(7);
        add_valid = 1'b1; add_bcd = 16'h0005;
        step(1);
        add_valid = 1'b0;
        total++; if (digits_c !== 16'h0005 || epulse_c !== 1'b0 || expired_c !== 1'b0) begin bad++; $display("FAIL sim_rescue: got %h p%b e%b want 0005 p0 e0", digits_c, epulse_c, expired_c); end
        total++; if (digits_a !== 16'h0028) begin bad++; $display("FAIL sim_rescue_main: got %h want 0028", digits_a); end
    endtask

    task automatic test_reset_and_over;
        test_reset();
        game_state = S_RUN;
        step(48);
        total++; if (digits_a !== 16'h0013 || tick_a !== 1'b1) begin bad++; $display("FAIL pre_rst: got %h/%b want 0013/1", digits_a, tick_a); end
        #2 rst = 1'b1;
        #1;
        total++; if (digits_a !== 16'h0025 || {tick_a, epulse_a, err_a} !== 3'b000) begin bad++; $display("FAIL async_rst: got %h/%b want 0025/000", digits_a, {tick_a, epulse_a, err_a}); end
        test_reset();
        game_state = S_RUN;
        step(32);
        total++; if (digits_a !== 16'h0017) begin bad++; $display("FAIL pre_over: got %h want 0017", digits_a); end
        game_state = S_OVER; add_valid = 1'b1; add_bcd = 16'h0010;
        step(10);
        add_valid = 1'b0;
        total++; if (digits_a !== 16'h0017 || err_a !== 1'b0 || tick_a !== 1'b0 || expired_a !== 1'b0) begin bad++; $display("FAIL over_hold: got %h e%b t%b x%b want 0017 e0 t0 x0", digits_a, err_a, tick_a, expired_a); end
    endtask

    initial begin
        test_reset();
        test_decrement();
        test_expire();
        test_pause();
        test_add();
        test_back_to_back();
        test_reset_and_over();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
